// File: rtl/tone_pkg.sv
// Shared tone constants: note reference periods at 100 MHz, the no-match code and meter state encoding.
// Transmit-side tone modules and the receive-side meter both draw on this table.
package tone_pkg;

  localparam int NUM_NOTES = 12;
  localparam logic [3:0] NOTE_NONE = 4'hF;

  // Index 0 is C4, index 11 is B4; full-period length in clk cycles.
  typedef logic [0:NUM_NOTES-1][31:0] period_table_t;

  localparam period_table_t NOTE_PERIOD = '{
    32'd382219, 32'd360776, 32'd340530, 32'd321409, 32'd303370, 32'd286344,
    32'd270277, 32'd255102, 32'd240790, 32'd227273, 32'd214519, 32'd202478
  };

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } meter_state_t;

  // Bounded lookup so an out-of-range index reads as zero instead of an undefined element.
  function automatic logic [31:0] note_period(input logic [3:0] idx);
    note_period = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (idx == 4'(i)) note_period = NOTE_PERIOD[i];
    end
  endfunction

endpackage

// File: rtl/note_classifier.sv
// Sequential nearest-note search: one reference compared per cycle, fixed 12-cycle latency after start.
// done is high in the cycle the last reference is compared; note_id/hit are valid only then.
module note_classifier
  import tone_pkg::*;
#(
  parameter int CNT_W     = 21,
  parameter int TOL_SHIFT = 6,
  parameter int REF_SHIFT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] period,
  output logic             busy,
  output logic             done,
  output logic [3:0]       note_id,
  output logic             hit
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_NOTES - 1);

  logic [3:0]     idx;
  logic [CNT_W:0] per_q;
  logic           found;
  logic [3:0]     found_idx;
  logic [CNT_W:0] ref_w;
  logic [CNT_W:0] diff;
  logic           cur_hit;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    ref_w   = (CNT_W+1)'(note_period(idx) >> REF_SHIFT);
    diff    = (per_q >= ref_w) ? per_q - ref_w : ref_w - per_q;
    cur_hit = busy && (diff <= (ref_w >> TOL_SHIFT));
  end

  // NOTE: state updates use <= so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      idx       <= '0;
      per_q     <= '0;
      found     <= 1'b0;
      found_idx <= NOTE_NONE;
    end else if (start) begin
      // A new start discards any search in flight.
      busy  <= 1'b1;
      idx   <= '0;
      per_q <= {1'b0, period};
      found <= 1'b0;
    end else if (busy) begin
      if (cur_hit && !found) begin
        found     <= 1'b1;
        found_idx <= idx;
      end
      if (idx == LAST_IDX) begin
        busy <= 1'b0;
        idx  <= '0;
      end else begin
        idx <= idx + 4'd1;
      end
    end
  end

  assign done    = busy && (idx == LAST_IDX);
  assign hit     = found || cur_hit;
  assign note_id = found ? found_idx : (cur_hit ? idx : NOTE_NONE);

endmodule

// File: rtl/tone_period_meter.sv
// Measures the rising-edge-to-rising-edge period of an asynchronous tone input and classifies it as C4..B4.
// REF_SHIFT scales the reference table down for clocks that are 2**REF_SHIFT slower than 100 MHz.
module tone_period_meter
  import tone_pkg::*;
#(
  parameter int CNT_W          = 21,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TOL_SHIFT      = 6,
  parameter int REF_SHIFT      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [3:0]       note_id,
  output logic             note_valid,
  output logic             no_signal
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic         sync1, sync2, prev;
  logic         rise;
  meter_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic         timeout;
  logic         cls_busy, cls_done, cls_hit;
  logic [3:0]   cls_note;

  // Two flops for metastability, a third to find the edge; the fixed delay cancels out of the period.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= tone_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      ST_IDLE:    if (rise) state_d = ST_MEASURE;
      ST_MEASURE: if (!rise && cnt == CNT_LAST) begin
        timeout = 1'b1;
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      note_id      <= NOTE_NONE;
      note_valid   <= 1'b0;
      no_signal    <= 1'b1;
    end else begin
      state_q      <= state_d;
      period_valid <= 1'b0;
      if (cls_busy && cls_done) begin
        note_id    <= cls_note;
        note_valid <= cls_hit;
      end
      // A rise in the final count cycle wins over the timeout.
      if (rise) begin
        cnt <= CNT_W'(1);
        if (state_q == ST_MEASURE) begin
          period       <= cnt;
          period_valid <= 1'b1;
          no_signal    <= 1'b0;
        end
      end else if (timeout) begin
        cnt        <= '0;
        no_signal  <= 1'b1;
        note_valid <= 1'b0;
        note_id    <= NOTE_NONE;
      end else if (state_q == ST_MEASURE) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  note_classifier #(
    .CNT_W     (CNT_W),
    .TOL_SHIFT (TOL_SHIFT),
    .REF_SHIFT (REF_SHIFT)
  ) u_classifier (
    .clk     (clk),
    .reset   (reset),
    .start   (period_valid),
    .period  (period),
    .busy    (cls_busy),
    .done    (cls_done),
    .note_id (cls_note),
    .hit     (cls_hit)
  );

endmodule

// File: tb/tb_tone_period_meter.sv
// Randomised bench for tone_period_meter: the stimulus side predicts events into a queue,
// an independent monitor pops them as the DUT reports periods and silence.
module tb_tone_period_meter;
  import tone_pkg::*;

  localparam int CNT_W     = 21;
  localparam int TIMEOUT   = 2000;
  localparam int TOL_SHIFT = 6;
  localparam int REF_SHIFT = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             tone_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [3:0]       note_id;
  logic             note_valid;
  logic             no_signal;

  tone_period_meter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT),
    .TOL_SHIFT      (TOL_SHIFT),
    .REF_SHIFT      (REF_SHIFT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tone_in      (tone_in),
    .period       (period),
    .period_valid (period_valid),
    .note_id      (note_id),
    .note_valid   (note_valid),
    .no_signal    (no_signal)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input bit ok, input longint actual, input longint expected);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: note periods scaled to the bench clock, first match within ref>>TOL_SHIFT.
  function automatic int ref_of(input int i);
    return int'(NOTE_PERIOD[i] >> REF_SHIFT);
  endfunction

  function automatic int classify(input int p);
    for (int i = 0; i < NUM_NOTES; i++) begin
      int r = ref_of(i);
      int d = (p > r) ? p - r : r - p;
      if (d <= (r >> TOL_SHIFT)) return i;
    end
    return 15;
  endfunction

  typedef enum int { EV_PERIOD, EV_SILENT } ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       per;
    bit       loose;
    int       note;
  } ev_t;

  ev_t exp_q[$];

  // Stimulus-side view of the pin: when the input last rose and whether a tone is present.
  int stim_cyc  = 0;
  int last_rise = 0;
  bit armed     = 1'b0;
  bit present   = 1'b0;
  bit prev_pin  = 1'b0;
  bit jitter    = 1'b0;
  bit last_jit  = 1'b0;

  task automatic drive(input bit v);
    ev_t e;
    @(negedge clk);
    if (jitter && v != prev_pin) #($urandom_range(0, 8));
    tone_in = v;
    stim_cyc++;
    if (armed && (stim_cyc - last_rise) >= TIMEOUT) begin
      if (present) begin
        e = '{kind: EV_SILENT, per: 0, loose: 1'b0, note: 15};
        exp_q.push_back(e);
      end
      armed   = 1'b0;
      present = 1'b0;
    end
    if (v && !prev_pin) begin
      if (armed) begin
        e = '{kind: EV_PERIOD, per: stim_cyc - last_rise, loose: jitter || last_jit,
              note: classify(stim_cyc - last_rise)};
        exp_q.push_back(e);
        present = 1'b1;
      end
      armed     = 1'b1;
      last_rise = stim_cyc;
      last_jit  = jitter;
    end
    prev_pin = v;
  endtask

  task automatic tone(input int p, input int n);
    repeat (n) for (int c = 0; c < p; c++) drive(bit'(c < p / 2));
  endtask

  task automatic quiet(input int n);
    repeat (n) drive(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    tone_in  = 1'b0;
    prev_pin = 1'b0;
    armed    = 1'b0;
    present  = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_period", period == '0, period, 0);
    check("rst_period_valid", period_valid == 1'b0, period_valid, 0);
    check("rst_note_id", note_id == NOTE_NONE, note_id, 15);
    check("rst_note_valid", note_valid == 1'b0, note_valid, 0);
    check("rst_no_signal", no_signal == 1'b1, no_signal, 1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: pops one prediction per reported period or silence and tracks the note result 13 cycles later.
  int mon_cyc   = 0;
  int last_pv   = -100000;
  int pend_at   = -1;
  int pend_note = 15;
  int cur_note  = 15;
  bit prev_pv   = 1'b0;
  bit prev_ns   = 1'b1;

  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      mon_cyc++;
      if (reset) begin
        pend_at  = -1;
        cur_note = 15;
        prev_pv  = 1'b0;
        prev_ns  = 1'b1;
      end else begin
        if (pend_at >= 0 && mon_cyc == pend_at - 1)
          check("note_early", note_id == 4'(cur_note), note_id, cur_note);
        if (pend_at >= 0 && mon_cyc == pend_at) begin
          cur_note = pend_note;
          check("note_id", note_id == 4'(pend_note), note_id, pend_note);
          check("note_valid", note_valid == (pend_note != 15), note_valid, pend_note != 15);
          pend_at = -1;
        end
        if (period_valid) begin
          check("pv_back_to_back", !prev_pv, prev_pv, 0);
          check("pv_expected", exp_q.size() != 0, period, 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pv_event_kind", e.kind == EV_PERIOD, int'(e.kind), int'(EV_PERIOD));
            if (e.kind == EV_PERIOD) begin
              int d = int'(period) - e.per;
              check("period", e.loose ? (d >= -1 && d <= 1) : (d == 0), period, e.per);
              check("no_signal_low", no_signal == 1'b0, no_signal, 0);
              pend_at   = mon_cyc + 13;
              pend_note = e.note;
            end
          end
          last_pv = mon_cyc;
        end
        if (no_signal && !prev_ns) begin
          check("silent_expected", exp_q.size() != 0, no_signal, 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("silent_event_kind", e.kind == EV_SILENT, int'(e.kind), int'(EV_SILENT));
          end
          check("timeout_delay", (mon_cyc - last_pv) == TIMEOUT - 1, mon_cyc - last_pv, TIMEOUT - 1);
          check("silent_note_id", note_id == NOTE_NONE, note_id, 15);
          check("silent_note_valid", note_valid == 1'b0, note_valid, 0);
          cur_note = 15;
        end
        prev_pv = period_valid;
        prev_ns = no_signal;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // E4 lock, then A4, then 1 kHz which matches nothing.
    tone(ref_of(4), 3);
    tone(ref_of(9), 3);
    tone(100000 >> REF_SHIFT, 3);

    // Tolerance edges around E4 (ref 1185, tolerance 18).
    tone(ref_of(4) + 18, 1);
    tone(ref_of(4) + 19, 1);
    tone(ref_of(4) - 18, 1);
    tone(ref_of(4) - 19, 1);
    tone(ref_of(4), 1);

    // Loss of signal after lock, then re-acquisition.
    tone(ref_of(0), 2);
    quiet(TIMEOUT + 20);
    tone(ref_of(0), 3);

    // Gap of TIMEOUT-1 is still a period; a gap of TIMEOUT is silence.
    tone(TIMEOUT - 1, 2);
    tone(TIMEOUT, 2);
    tone(ref_of(2), 2);

    // Reset between rises, then reset in the middle of a search.
    quiet(300);
    do_reset();
    tone(ref_of(7), 3);
    drive(1'b1);
    repeat (8) drive(1'b1);
    do_reset();
    tone(ref_of(11), 3);

    // Random periods, some near a note and some arbitrary.
    repeat (8) begin
      int p;
      if ($urandom_range(0, 1) == 1)
        p = ref_of(int'($urandom_range(0, 11))) + int'($urandom_range(0, 50)) - 25;
      else
        p = int'($urandom_range(400, 1600));
      tone(p, 1);
    end
    tone(ref_of(5), 1);

    // Asynchronous phase on every edge: periods within one cycle of nominal.
    jitter = 1'b1;
    repeat (6) tone(ref_of(int'($urandom_range(0, 11))), 1);
    jitter = 1'b0;
    tone(ref_of(3), 1);

    quiet(40);
    check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    check("no_pending_note", pend_at < 0, pend_at, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
